// File: rtl/axi_slv_mem_bridge_if.sv
// Signal bundle between the axi_slv request/response port, the bridge and the SRAM macro.
// The slave modport is the bridge's view; master is the front-end plus memory side.
interface axi_slv_mem_bridge_if #(
  parameter int addr_bits = 32,
  parameter int data_bits = 64,
  parameter int abits     = 18
);
  localparam int dbytes = data_bits / 8;

  logic                 i_req_valid;
  logic [addr_bits-1:0] i_req_addr;
  logic [7:0]           i_req_size;
  logic                 i_req_write;
  logic [data_bits-1:0] i_req_wdata;
  logic [dbytes-1:0]    i_req_wstrb;
  logic                 i_req_last;
  logic                 o_req_ready;
  logic                 o_resp_valid;
  logic [data_bits-1:0] o_resp_rdata;
  logic                 o_resp_err;
  logic                 o_mem_en;
  logic                 o_mem_we;
  logic [abits-1:0]     o_mem_addr;
  logic [dbytes-1:0]    o_mem_wstrb;
  logic [data_bits-1:0] o_mem_wdata;
  logic [data_bits-1:0] i_mem_rdata;
  // Registered copy of i_req_last, kept observable for debug.
  logic                 o_dbg_req_last;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_size, i_req_write, i_req_wdata, i_req_wstrb,
           i_req_last, i_mem_rdata,
    output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err, o_mem_en, o_mem_we,
           o_mem_addr, o_mem_wstrb, o_mem_wdata, o_dbg_req_last
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_size, i_req_write, i_req_wdata, i_req_wstrb,
           i_req_last, i_mem_rdata,
    input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err, o_mem_en, o_mem_we,
           o_mem_addr, o_mem_wstrb, o_mem_wdata, o_dbg_req_last
  );
endinterface

// File: rtl/axi_slv_mem_bridge.sv
// Handshaking bridge from the axi_slv request port to a synchronous SRAM with 1..4 cycle
// read latency: one memory access per request, range/size errors answered without touching memory.
module axi_slv_mem_bridge #(
  parameter int abits            = 18,
  parameter int log2_dbytes      = 3,
  parameter int rd_latency       = 1,
  parameter int sysbus_addr_bits = 32
) (
  input logic                 i_clk,
  input logic                 i_nrst,
  axi_slv_mem_bridge_if.slave bus
);
  localparam int         dbytes   = 1 << log2_dbytes;
  localparam int         dbits    = 8 * dbytes;
  localparam logic [8:0] max_size = 9'(dbytes);
  localparam logic [1:0] cnt_init = 2'(rd_latency - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic [abits-1:0]   addr_q, addr_d;
  logic [dbits-1:0]   wdata_q, wdata_d;
  logic [dbytes-1:0]  wstrb_q, wstrb_d;
  logic               write_q, write_d;
  logic               err_q, err_d;
  logic               last_q, last_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [dbits-1:0]   rdata_q, rdata_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [abits-1:0]   mem_addr_q, mem_addr_d;
  logic [dbytes-1:0]  mem_wstrb_q, mem_wstrb_d;
  logic [dbits-1:0]   mem_wdata_q, mem_wdata_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic               req_bad;

  assign req_bad = (|bus.i_req_addr[sysbus_addr_bits-1:abits]) ||
                   ({1'b0, bus.i_req_size} > max_size);

  // Next state; the registered outputs are derived from the state being entered so that
  // they line up exactly with ACCESS and RESP.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    write_d = write_q;
    err_d   = err_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (bus.i_req_valid) begin
          last_d = bus.i_req_last;
          err_d  = req_bad;
          if (req_bad) begin
            state_d = RESP;
          end else begin
            addr_d  = bus.i_req_addr[abits-1:0];
            wdata_d = bus.i_req_wdata;
            wstrb_d = bus.i_req_wstrb;
            write_d = bus.i_req_write;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (write_q) begin
          state_d = RESP;
        end else if (rd_latency == 1) begin
          rdata_d = bus.i_mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_init;
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        // Capture on the edge where the countdown expires: ACCESS plus rd_latency-1 waits.
        cnt_d = cnt_q - 2'd1;
        if (cnt_d == 2'd0) begin
          rdata_d = bus.i_mem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mem_en_d     = (state_d == ACCESS);
    mem_we_d     = mem_en_d && write_d;
    mem_addr_d   = mem_en_d ? addr_d : '0;
    mem_wstrb_d  = mem_we_d ? wstrb_d : '0;
    mem_wdata_d  = mem_we_d ? wdata_d : '0;
    resp_valid_d = (state_d == RESP);
    resp_err_d   = resp_valid_d && err_d;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wstrb_q  <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      write_q      <= write_d;
      err_q        <= err_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.o_req_ready    = (state_q == IDLE);
  assign bus.o_resp_valid   = resp_valid_q;
  assign bus.o_resp_rdata   = rdata_q;
  assign bus.o_resp_err     = resp_err_q;
  assign bus.o_mem_en       = mem_en_q;
  assign bus.o_mem_we       = mem_we_q;
  assign bus.o_mem_addr     = mem_addr_q;
  assign bus.o_mem_wstrb    = mem_wstrb_q;
  assign bus.o_mem_wdata    = mem_wdata_q;
  assign bus.o_dbg_req_last = last_q;
endmodule

// File: tb/tb_axi_slv_mem_bridge.sv
// Bench for axi_slv_mem_bridge: three bridges (read latency 1, 3, 4) share one request stream,
// each with its own SRAM model; results are compared against a byte-level reference memory.
module tb_axi_slv_mem_bridge;
  localparam int NL    = 3;
  localparam int ABITS = 18;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  size;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_last = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_size = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  int          cyc = 0;

  int checks = 0;
  int passes = 0;

  logic        cur_wr;
  logic [31:0] cur_addr;
  logic        cur_last;
  logic        got_err   [NL];
  logic [63:0] got_rdata [NL];
  logic [17:0] got_maddr [NL];
  int          got_lat   [NL];
  int          got_en    [NL];
  int          got_we    [NL];
  logic        got_last;

  logic [7:0]  model_mem [int];
  vec_t        vecs [14];

  wire         ready_w    [NL];
  wire         zero_w     [NL];
  wire         err_w      [NL];
  wire         dbg_last_w [NL];
  wire [63:0]  rdata_w    [NL];
  wire [17:0]  maddr_w    [NL];
  wire [31:0]  acc_cyc_w  [NL];
  wire [31:0]  resp_cyc_w [NL];
  wire [31:0]  en_cnt_w   [NL];
  wire [31:0]  we_cnt_w   [NL];
  wire [31:0]  resp_cnt_w [NL];
  wire [31:0]  viol_w     [NL];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

    axi_slv_mem_bridge_if #(.addr_bits(32), .data_bits(64), .abits(ABITS)) bus ();

    axi_slv_mem_bridge #(
      .abits(ABITS), .log2_dbytes(3), .rd_latency(LAT), .sysbus_addr_bits(32)
    ) dut (
      .i_clk (clk),
      .i_nrst(nrst),
      .bus   (bus)
    );

    bit   [63:0] sram [0:32767];
    logic [63:0] rd_comb;
    logic [63:0] rd_pipe [1:3];
    int          acc_cyc = 0, resp_cyc = 0, en_cnt = 0, we_cnt = 0, resp_cnt = 0, viol = 0;
    logic [63:0] rdata_cap = '0;
    logic        err_cap = 1'b0;
    logic [17:0] maddr_cap = '0;

    assign bus.i_req_valid = req_valid;
    assign bus.i_req_addr  = req_addr;
    assign bus.i_req_size  = req_size;
    assign bus.i_req_write = req_write;
    assign bus.i_req_wdata = req_wdata;
    assign bus.i_req_wstrb = req_wstrb;
    assign bus.i_req_last  = req_last;

    // SRAM: combinational array read followed by LAT-1 output register stages.
    always_comb rd_comb = (bus.o_mem_en && !bus.o_mem_we) ? sram[bus.o_mem_addr[17:3]] : 64'h0;

    always @(posedge clk) begin
      if (bus.o_mem_en && bus.o_mem_we)
        for (int k = 0; k < 8; k++)
          if (bus.o_mem_wstrb[k]) sram[bus.o_mem_addr[17:3]][8*k +: 8] <= bus.o_mem_wdata[8*k +: 8];
      rd_pipe[1] <= rd_comb;
      rd_pipe[2] <= rd_pipe[1];
      rd_pipe[3] <= rd_pipe[2];
    end

    if (LAT == 1) begin : g_l1
      assign bus.i_mem_rdata = rd_comb;
    end else begin : g_ln
      assign bus.i_mem_rdata = rd_pipe[LAT-1];
    end

    always @(posedge clk) begin
      if (bus.i_req_valid && bus.o_req_ready) acc_cyc <= cyc;
      if (bus.o_mem_en) begin
        en_cnt    <= en_cnt + 1;
        maddr_cap <= bus.o_mem_addr;
      end
      if (bus.o_mem_we) we_cnt <= we_cnt + 1;
      if (bus.o_resp_valid) begin
        resp_cnt  <= resp_cnt + 1;
        resp_cyc  <= cyc;
        rdata_cap <= bus.o_resp_rdata;
        err_cap   <= bus.o_resp_err;
      end
      if ((!bus.o_mem_en && (bus.o_mem_we || (|bus.o_mem_addr) || (|bus.o_mem_wstrb) ||
                             (|bus.o_mem_wdata))) ||
          (!bus.o_resp_valid && ((|bus.o_resp_rdata) || bus.o_resp_err)))
        viol <= viol + 1;
    end

    assign ready_w[g]    = bus.o_req_ready;
    assign zero_w[g]     = !bus.o_mem_en && !bus.o_mem_we && (bus.o_mem_addr == '0) &&
                           (bus.o_mem_wstrb == '0) && (bus.o_mem_wdata == '0) &&
                           !bus.o_resp_valid && (bus.o_resp_rdata == '0) && !bus.o_resp_err &&
                           !bus.o_dbg_req_last;
    assign err_w[g]      = err_cap;
    assign dbg_last_w[g] = bus.o_dbg_req_last;
    assign rdata_w[g]    = rdata_cap;
    assign maddr_w[g]    = maddr_cap;
    assign acc_cyc_w[g]  = acc_cyc;
    assign resp_cyc_w[g] = resp_cyc;
    assign en_cnt_w[g]   = en_cnt;
    assign we_cnt_w[g]   = we_cnt;
    assign resp_cnt_w[g] = resp_cnt;
    assign viol_w[g]     = viol;
  end

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : ((l == 1) ? 3 : 4);
  endfunction

  function automatic logic model_err(input logic [31:0] a, input logic [7:0] s);
    return (a[31:ABITS] != '0) || (s > 8'd8);
  endfunction

  function automatic logic [63:0] model_read(input logic [31:0] a);
    logic [63:0] r = '0;
    int          base = int'({a[31:3], 3'b000});
    for (int k = 0; k < 8; k++)
      if (model_mem.exists(base + k)) r[8*k +: 8] = model_mem[base + k];
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    int base = int'({a[31:3], 3'b000});
    for (int k = 0; k < 8; k++)
      if (s[k]) model_mem[base + k] = d[8*k +: 8];
  endtask

  task automatic checkVal(input string name, input int lane, input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s lane%0d: got 0x%0h, expected 0x%0h", name, lane, got, exp);
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    $display("[TB] FAIL %s: timed out waiting for the bridge", name);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!(ready_w[0] && ready_w[1] && ready_w[2]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeoutFail("wait_idle");
  endtask

  // One request held for exactly the accepting edge, then withdrawn with garbage on the bus.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [7:0] size,
                               input logic [63:0] wdata, input logic [7:0] wstrb,
                               input logic last);
    int  base_resp [NL];
    int  base_en   [NL];
    int  base_we   [NL];
    int  n = 0;
    bit  done = 1'b0;
    waitIdle();
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      base_resp[l] = int'(resp_cnt_w[l]);
      base_en[l]   = int'(en_cnt_w[l]);
      base_we[l]   = int'(we_cnt_w[l]);
    end
    cur_wr = wr; cur_addr = addr; cur_last = last;
    req_write = wr; req_addr = addr; req_size = size; req_wdata = wdata; req_wstrb = wstrb;
    req_last = last; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = {$urandom, $urandom};
    req_write = 1'(~wr);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      done = 1'b1;
      for (int l = 0; l < NL; l++)
        if (int'(resp_cnt_w[l]) == base_resp[l]) done = 1'b0;
    end
    if (!done) timeoutFail("response");
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      got_err[l]   = err_w[l];
      got_rdata[l] = rdata_w[l];
      got_maddr[l] = maddr_w[l];
      got_lat[l]   = int'(resp_cyc_w[l]) - int'(acc_cyc_w[l]);
      got_en[l]    = int'(en_cnt_w[l]) - base_en[l];
      got_we[l]    = int'(we_cnt_w[l]) - base_we[l];
    end
    got_last = dbg_last_w[0];
  endtask

  task automatic checkOutput(input string tag, input logic exp_err, input logic [63:0] exp_rdata);
    for (int l = 0; l < NL; l++) begin
      int exp_lat = exp_err ? 1 : (cur_wr ? 2 : 1 + lat_of(l));
      checkVal({tag, "_err"}, l, 64'(got_err[l]), 64'(exp_err));
      checkVal({tag, "_rdata"}, l, got_rdata[l], exp_rdata);
      checkVal({tag, "_latency"}, l, 64'(got_lat[l]), 64'(exp_lat));
      checkVal({tag, "_mem_en_pulses"}, l, 64'(got_en[l]), exp_err ? 64'd0 : 64'd1);
      checkVal({tag, "_mem_we_pulses"}, l, 64'(got_we[l]), (exp_err || !cur_wr) ? 64'd0 : 64'd1);
      if (!exp_err) checkVal({tag, "_mem_addr"}, l, 64'(got_maddr[l]), 64'(cur_addr[17:0]));
    end
    checkVal({tag, "_dbg_last"}, 0, 64'(got_last), 64'(cur_last));
  endtask

  initial begin
    int          acc_at [3];
    int          acc_n;
    int          c;
    int          snap_en [NL];
    int          snap_resp [NL];
    int          snap_we [NL];
    logic        wr, e;
    logic [31:0] a;
    logic [7:0]  s, st;
    logic [63:0] d, exp_rd;
    int          r;

    vecs[0]  = '{1'b1, 32'h0000_0100, 8'd8,  64'h1122334455667788, 8'hFF, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 32'h0000_0100, 8'd8,  64'h0,                8'h00, 1'b0, 64'h1122334455667788};
    vecs[2]  = '{1'b1, 32'h0000_0100, 8'd4,  64'hAAAAAAAABBBBBBBB, 8'h0F, 1'b0, 64'h0};
    vecs[3]  = '{1'b0, 32'h0000_0100, 8'd8,  64'h0,                8'h00, 1'b0, 64'h11223344BBBBBBBB};
    vecs[4]  = '{1'b0, 32'h0004_0000, 8'd8,  64'h0,                8'h00, 1'b1, 64'h0};
    vecs[5]  = '{1'b0, 32'h0000_0100, 8'd16, 64'h0,                8'h00, 1'b1, 64'h0};
    vecs[6]  = '{1'b1, 32'h0003_FFF8, 8'd8,  64'hCAFEF00DDEADBEEF, 8'hFF, 1'b0, 64'h0};
    vecs[7]  = '{1'b0, 32'h0003_FFF8, 8'd8,  64'h0,                8'h00, 1'b0, 64'hCAFEF00DDEADBEEF};
    vecs[8]  = '{1'b1, 32'h0000_0200, 8'd8,  64'h5555555555555555, 8'h00, 1'b0, 64'h0};
    vecs[9]  = '{1'b0, 32'h0000_0200, 8'd8,  64'h0,                8'h00, 1'b0, 64'h0};
    vecs[10] = '{1'b1, 32'h0004_0000, 8'd8,  64'h0123456789ABCDEF, 8'hFF, 1'b1, 64'h0};
    vecs[11] = '{1'b0, 32'h0000_0000, 8'd8,  64'h0,                8'h00, 1'b0, 64'h0};
    vecs[12] = '{1'b0, 32'h0000_0100, 8'd9,  64'h0,                8'h00, 1'b1, 64'h0};
    vecs[13] = '{1'b0, 32'h0000_0100, 8'd8,  64'h0,                8'h00, 1'b0, 64'h11223344BBBBBBBB};

    repeat (2) @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      checkVal("reset_outputs_zero", l, 64'(zero_w[l]), 64'd1);
      checkVal("reset_req_ready", l, 64'(ready_w[l]), 64'd1);
    end
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, vecs[i].wstrb,
                    1'(i % 2));
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_rdata);
      if (vecs[i].wr && !vecs[i].exp_err) model_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
    end

    // Valid held high across three writes: accepts only when back in IDLE.
    waitIdle();
    @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      snap_we[l]   = int'(we_cnt_w[l]);
      snap_resp[l] = int'(resp_cnt_w[l]);
    end
    req_write = 1'b1; req_addr = 32'h300; req_size = 8'd8; req_wdata = 64'hFEEDFACE00C0FFEE;
    req_wstrb = 8'hFF; req_last = 1'b1; req_valid = 1'b1;
    acc_n = 0; c = 0;
    while (acc_n < 3 && c < 15) begin
      if (ready_w[0]) begin
        acc_at[acc_n] = c;
        acc_n++;
      end
      @(posedge clk);
      #1;
      if (acc_n == 3) req_valid = 1'b0;
      @(negedge clk);
      c++;
    end
    req_valid = 1'b0;
    checkVal("b2b_accept_count", 0, 64'(acc_n), 64'd3);
    if (acc_n == 3) begin
      checkVal("b2b_accept0", 0, 64'(acc_at[0]), 64'd0);
      checkVal("b2b_accept1", 0, 64'(acc_at[1]), 64'd3);
      checkVal("b2b_accept2", 0, 64'(acc_at[2]), 64'd6);
    end
    repeat (4) @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      checkVal("b2b_we_pulses", l, 64'(int'(we_cnt_w[l]) - snap_we[l]), 64'd3);
      checkVal("b2b_responses", l, 64'(int'(resp_cnt_w[l]) - snap_resp[l]), 64'd3);
    end
    model_write(32'h300, 64'hFEEDFACE00C0FFEE, 8'hFF);

    // Reset while the latency-3/4 bridges sit in their read wait.
    waitIdle();
    @(negedge clk);
    req_write = 1'b0; req_addr = 32'h100; req_size = 8'd8; req_last = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    for (int l = 0; l < NL; l++) begin
      checkVal("midreset_outputs_zero", l, 64'(zero_w[l]), 64'd1);
      checkVal("midreset_req_ready", l, 64'(ready_w[l]), 64'd1);
      snap_en[l]   = int'(en_cnt_w[l]);
      snap_resp[l] = int'(resp_cnt_w[l]);
    end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (8) @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      checkVal("midreset_no_response", l, 64'(int'(resp_cnt_w[l]) - snap_resp[l]), 64'd0);
      checkVal("midreset_no_mem_en", l, 64'(int'(en_cnt_w[l]) - snap_en[l]), 64'd0);
    end
    applyStimulus(1'b0, 32'h100, 8'd8, 64'h0, 8'h00, 1'b1);
    checkOutput("after_reset_read", 1'b0, model_read(32'h100));

    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 32'h1000 + 32'(8 * $urandom_range(0, 7));
      r  = int'($urandom_range(0, 9));
      if (r == 0) a = a | (32'h1 << $urandom_range(ABITS, 31));
      s  = (r == 1) ? 8'($urandom_range(9, 255)) : 8'($urandom_range(1, 8));
      d  = {$urandom, $urandom};
      st = 8'($urandom);
      e  = model_err(a, s);
      exp_rd = (wr || e) ? 64'h0 : model_read(a);
      applyStimulus(wr, a, s, d, st, 1'($urandom_range(0, 1)));
      checkOutput($sformatf("rand%0d", t), e, exp_rd);
      if (wr && !e) model_write(a, d, st);
    end

    for (int l = 0; l < NL; l++)
      checkVal("idle_outputs_zero_cycles", l, 64'(viol_w[l]), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
